pc_gen: RTL and testbench

Parametrised fetch-address generator for the core front end. It is the next generation of the fetch PC register. It adds configurable width, reset vector and step, and prioritised redirect sources. A redirect that arrives during a stall is held until fetch resumes. A circular return-address stack (RAS) predicts return targets. The block sits between the branch/jump resolution logic and instruction-memory address input, and drives the fetch address every cycle.

---
 rtl/pc_gen.sv | 110 +++++++++++
 tb/tb_pc_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-address generator: registered PC with prioritised redirect sources,
// a stall-tolerant pending redirect and a circular return-address stack.
module pc_gen #(
    parameter int PC_W      = 27,
    parameter int RESET_PC  = 16308,
    parameter int STEP      = 4,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         n_stall,
    input  logic                         redirect_en,
    input  logic [PC_W-1:0]              redirect_pc,
    input  logic                         jump_en,
    input  logic [PC_W-1:0]              jump_pc,
    input  logic                         call_en,
    input  logic [PC_W-1:0]              link_pc,
    input  logic                         ret_en,
    output logic [PC_W-1:0]              pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         pend_valid
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PC_W-1:0]  RST_PC_V = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]  STEP_V   = PC_W'(STEP);
    localparam logic [CNT_W-1:0] DEPTH_V  = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_V);

    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        top_d        = top_q;
        cnt_d        = cnt_q;
        wr_en        = 1'b0;
        wr_idx       = top_q;
        if (!n_stall) begin
            if (redirect_en) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = redirect_pc;
            end
        end else begin
            pend_valid_d = 1'b0;
            if (redirect_en) begin
                pc_d = redirect_pc;
            end else if (pend_valid_q) begin
                pc_d = pend_pc_q;
            end else begin
                if (ret_en && !empty)  pc_d = ras_q[top_q];
                else if (jump_en)      pc_d = jump_pc;
                else                   pc_d = pc_q + STEP_V;
                // call+ret swaps the top entry in place; an empty stack gains it
                if (call_en && ret_en) begin
                    wr_en = 1'b1;
                    if (empty) cnt_d = CNT_W'(1);
                end else if (call_en) begin
                    wr_en  = 1'b1;
                    wr_idx = top_q + PTR_W'(1);
                    top_d  = top_q + PTR_W'(1);
                    if (!full) cnt_d = cnt_q + CNT_W'(1);
                end else if (ret_en && !empty) begin
                    top_d = top_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RST_PC_V;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            top_q        <= '0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            top_q        <= top_d;
            cnt_q        <= cnt_d;
        end
    end

    // Stack storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (wr_en) ras_q[wr_idx] <= link_pc;
    end

    assign pc         = pc_q;
    assign ras_count  = cnt_q;
    assign ras_empty  = empty;
    assign ras_full   = full;
    assign pend_valid = pend_valid_q;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected PCs are queued as stimulus is driven
// and popped once the corresponding edge has updated the DUT.
module tb_pc_gen;
    localparam int PC_W = 27;

    logic            clk = 1'b0;
    logic            rst;
    logic            n_stall, redirect_en, jump_en, call_en, ret_en;
    logic [PC_W-1:0] redirect_pc, jump_pc, link_pc;
    logic [PC_W-1:0] pc;
    logic [3:0]      ras_count;
    logic            ras_empty, ras_full, pend_valid;

    int vectors = 0;
    int errs    = 0;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] e;

    pc_gen #(.PC_W(PC_W), .RESET_PC(16308), .STEP(4), .RAS_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .n_stall(n_stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .jump_en(jump_en), .jump_pc(jump_pc),
        .call_en(call_en), .link_pc(link_pc), .ret_en(ret_en),
        .pc(pc), .ras_count(ras_count), .ras_empty(ras_empty),
        .ras_full(ras_full), .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic ns, input logic re, input logic [PC_W-1:0] rpc,
                       input logic je, input logic [PC_W-1:0] jpc,
                       input logic ce, input logic [PC_W-1:0] lpc, input logic rt);
        n_stall = ns; redirect_en = re; redirect_pc = rpc;
        jump_en = je; jump_pc = jpc; call_en = ce; link_pc = lpc; ret_en = rt;
        @(posedge clk); #1;
        n_stall = 1'b1; redirect_en = 1'b0; jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        redirect_pc = $urandom; jump_pc = $urandom; link_pc = $urandom;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (pc !== 27'd16308 || ras_count !== 4'd0 || ras_empty !== 1'b1 ||
            ras_full !== 1'b0 || pend_valid !== 1'b0) begin
            $display("FAIL reset: pc=%0d cnt=%0d empty=%b full=%b pend=%b, want 16308 0 1 0 0",
                     pc, ras_count, ras_empty, ras_full, pend_valid);
            errs++;
        end
        rst = 1'b0;
        exp_q.push_back(27'd16312);
        exp_q.push_back(27'd16316);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 0);
            e = exp_q.pop_front(); vectors++;
            if (pc !== e) begin $display("FAIL seq[%0d]: pc=%h want %h", i, pc, e); errs++; end
        end
    endtask

    task automatic test_wrap;
        exp_q.push_back(27'h7FFFFFC);
        cyc(1, 1, 27'h7FFFFFC, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e) begin $display("FAIL wrap_set: pc=%h want %h", pc, e); errs++; end
        exp_q.push_back(27'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e) begin $display("FAIL wrap: pc=%h want %h", pc, e); errs++; end
    endtask

    task automatic test_priority;
        exp_q.push_back(27'h4);
        cyc(1, 0, 0, 0, 0, 1, 27'h300, 0);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_count !== 4'd1) begin
            $display("FAIL prio_call: pc=%h cnt=%0d want %h 1", pc, ras_count, e); errs++;
        end
        exp_q.push_back(27'h100);
        cyc(1, 1, 27'h100, 1, 27'h200, 0, 0, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_count !== 4'd1) begin
            $display("FAIL prio_redirect: pc=%h cnt=%0d want %h 1", pc, ras_count, e); errs++;
        end
        exp_q.push_back(27'h200);
        cyc(1, 0, 0, 1, 27'h200, 0, 0, 0);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e) begin $display("FAIL prio_jump: pc=%h want %h", pc, e); errs++; end
        exp_q.push_back(27'h300);
        cyc(1, 0, 0, 1, 27'h250, 0, 0, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_empty !== 1'b1) begin
            $display("FAIL prio_ret_over_jump: pc=%h empty=%b want %h 1", pc, ras_empty, e); errs++;
        end
    endtask

    task automatic test_stall;
        cyc(0, 1, 27'h400, 0, 0, 0, 0, 0);
        cyc(0, 1, 27'h500, 1, 27'h999, 1, 27'h777, 0);
        vectors++;
        if (pc !== 27'h300 || pend_valid !== 1'b1 || ras_count !== 4'd0) begin
            $display("FAIL stall_hold: pc=%h pend=%b cnt=%0d want 300 1 0", pc, pend_valid, ras_count);
            errs++;
        end
        exp_q.push_back(27'h500);
        cyc(1, 0, 0, 1, 27'h999, 0, 0, 0);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || pend_valid !== 1'b0) begin
            $display("FAIL stall_release: pc=%h pend=%b want %h 0", pc, pend_valid, e); errs++;
        end
        cyc(0, 1, 27'h500, 0, 0, 0, 0, 0);
        exp_q.push_back(27'h600);
        cyc(1, 1, 27'h600, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || pend_valid !== 1'b0) begin
            $display("FAIL stall_override: pc=%h pend=%b want %h 0", pc, pend_valid, e); errs++;
        end
        cyc(0, 1, 27'h700, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 27'h123, 0, 0, 0);
        exp_q.push_back(27'h700);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e) begin $display("FAIL long_stall: pc=%h want %h", pc, e); errs++; end
    endtask

    task automatic test_ras_overflow;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(27'(27'h700 + 4 * k));
            cyc(1, 0, 0, 0, 0, 1, 27'(16 * k), 0);
            e = exp_q.pop_front(); vectors++;
            if (pc !== e || ras_count !== 4'((k > 8) ? 8 : k)) begin
                $display("FAIL push[%0d]: pc=%h cnt=%0d want %h", k, pc, ras_count, e); errs++;
            end
        end
        vectors++;
        if (ras_full !== 1'b1) begin $display("FAIL full: ras_full=%b want 1", ras_full); errs++; end
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(27'(16 * (9 - k)));
            cyc(1, 0, 0, 0, 0, 0, 0, 1);
            e = exp_q.pop_front(); vectors++;
            if (pc !== e || ras_count !== 4'(7 - k)) begin
                $display("FAIL pop[%0d]: pc=%h cnt=%0d want %h %0d", k, pc, ras_count, e, 7 - k); errs++;
            end
        end
        exp_q.push_back(27'h24);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_empty !== 1'b1 || ras_count !== 4'd0) begin
            $display("FAIL ret_empty: pc=%h empty=%b want %h 1", pc, ras_empty, e); errs++;
        end
    endtask

    task automatic test_call_ret;
        cyc(1, 0, 0, 0, 0, 1, 27'h40, 0);
        exp_q.push_back(27'h40);
        cyc(1, 0, 0, 0, 0, 1, 27'h80, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_count !== 4'd1) begin
            $display("FAIL call_ret: pc=%h cnt=%0d want %h 1", pc, ras_count, e); errs++;
        end
        exp_q.push_back(27'h80);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_count !== 4'd0) begin
            $display("FAIL call_ret_next: pc=%h cnt=%0d want %h 0", pc, ras_count, e); errs++;
        end
        exp_q.push_back(27'h84);
        cyc(1, 0, 0, 0, 0, 1, 27'hA0, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_count !== 4'd1) begin
            $display("FAIL call_ret_empty: pc=%h cnt=%0d want %h 1", pc, ras_count, e); errs++;
        end
        exp_q.push_back(27'hA0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e) begin $display("FAIL call_ret_empty_pop: pc=%h want %h", pc, e); errs++; end
    endtask

    task automatic test_reset_mid;
        cyc(1, 0, 0, 0, 0, 1, 27'h55, 0);
        cyc(0, 1, 27'hB00, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (pc !== 27'd16308 || pend_valid !== 1'b0 || ras_count !== 4'd0) begin
            $display("FAIL reset_mid: pc=%0d pend=%b cnt=%0d want 16308 0 0", pc, pend_valid, ras_count);
            errs++;
        end
        @(negedge clk) rst = 1'b0;
        exp_q.push_back(27'd16312);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        e = exp_q.pop_front(); vectors++;
        if (pc !== e || ras_empty !== 1'b1) begin
            $display("FAIL reset_mid_resume: pc=%0d empty=%b want %0d 1", pc, ras_empty, e); errs++;
        end
    endtask

    initial begin
        n_stall = 1'b1; redirect_en = 1'b0; jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        redirect_pc = '0; jump_pc = '0; link_pc = '0;
        rst = 1'b1;
        #2;
        vectors++;
        if (pc !== 27'd16308 || ras_empty !== 1'b1 || pend_valid !== 1'b0) begin
            $display("FAIL async_reset: pc=%0d empty=%b pend=%b want 16308 1 0", pc, ras_empty, pend_valid);
            errs++;
        end
        test_reset();
        test_wrap();
        test_priority();
        test_stall();
        test_ras_overflow();
        test_call_ret();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
